// File: rtl/arith_pipe_pkg.sv
// ============================================================================
// Module      : arith_pipe_pkg
// Description : Shared constants and helpers for the arith_pipe pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arith_pipe_pkg;

    localparam int c_DEFAULT_W  = 10;
    localparam int c_NUM_STAGES = 3;

    typedef logic [1:0] level_t;

    // Population count of the stage valid bits.
    function automatic level_t count_valid(input logic [c_NUM_STAGES-1:0] v);
        level_t n;
        n = '0;
        for (int i = 0; i < c_NUM_STAGES; i++) begin
            n = n + level_t'(v[i]);
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arith_pipe_slice.sv
// ============================================================================
// Module      : arith_pipe_slice
// Description : One valid/ready register slice with a combinational ready path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arith_pipe_slice #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [PW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [PW-1:0] o_data
);

    logic          r_valid;
    logic [PW-1:0] r_data;

    // Loads when empty or when the current content leaves this cycle.
    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (o_ready) begin
                r_valid <= i_valid;
            end
            if (i_valid && o_ready) begin
                r_data <= i_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/arith_pipe.sv
// ============================================================================
// Module      : arith_pipe
// Description : Three-stage elastic pipeline computing ((a+b)+(c-d))*d.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arith_pipe
    import arith_pipe_pkg::*;
#(
    parameter int W    = c_DEFAULT_W,
    parameter int MULW = W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [W-1:0]    c,
    input  logic [W-1:0]    d,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [MULW-1:0] out_f,
    output logic [1:0]      level
);

    localparam int c_S1W = 3 * W;
    localparam int c_S2W = 2 * W;

    logic [W-1:0]     w_x1;
    logic [W-1:0]     w_x2;
    logic [c_S1W-1:0] w_s1_q;
    logic [W-1:0]     w_s1_x1;
    logic [W-1:0]     w_s1_x2;
    logic [W-1:0]     w_s1_d;
    logic             w_v1;
    logic             w_rdy2;

    logic [W-1:0]     w_x3;
    logic [c_S2W-1:0] w_s2_q;
    logic [W-1:0]     w_s2_x3;
    logic [W-1:0]     w_s2_d;
    logic             w_v2;
    logic             w_rdy3;

    logic [MULW-1:0]  w_prod;

    assign w_x1 = a + b;
    assign w_x2 = c - d;

    arith_pipe_slice #(.PW(c_S1W)) u_stage1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  ({w_x1, w_x2, d}),
        .o_valid (w_v1),
        .i_ready (w_rdy2),
        .o_data  (w_s1_q)
    );

    assign {w_s1_x1, w_s1_x2, w_s1_d} = w_s1_q;
    assign w_x3 = w_s1_x1 + w_s1_x2;

    arith_pipe_slice #(.PW(c_S2W)) u_stage2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_valid (w_v1),
        .o_ready (w_rdy2),
        .i_data  ({w_x3, w_s1_d}),
        .o_valid (w_v2),
        .i_ready (w_rdy3),
        .o_data  (w_s2_q)
    );

    assign {w_s2_x3, w_s2_d} = w_s2_q;

    // Multiplying at MULW bits yields exactly the low MULW bits of the full product.
    assign w_prod = MULW'(w_s2_x3) * MULW'(w_s2_d);

    arith_pipe_slice #(.PW(MULW)) u_stage3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (flush),
        .i_valid (w_v2),
        .o_ready (w_rdy3),
        .i_data  (w_prod),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (out_f)
    );

    assign level = count_valid({out_valid, w_v2, w_v1});

endmodule

`default_nettype wire

// File: tb/tb_arith_pipe.sv
// ============================================================================
// Module      : tb_arith_pipe
// Description : Randomised and directed bench for arith_pipe against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arith_pipe;

    localparam int W    = 10;
    localparam int MULW = 10;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b1;
    logic            in_valid  = 1'b0;
    logic            flush     = 1'b0;
    logic            out_ready = 1'b0;
    logic [W-1:0]    a = '0, b = '0, c = '0, d = '0;
    logic            in_ready;
    logic            out_valid;
    logic [MULW-1:0] out_f;
    logic [1:0]      level;

    arith_pipe #(.W(W), .MULW(MULW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .level     (level)
    );

    always #5 clk = ~clk;

    int n_vec   = 0;
    int n_err   = 0;
    int emitted = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain modular arithmetic.
    function automatic int unsigned model_f(input int unsigned fa, fb, fc, fd);
        int unsigned m, x1, x2, x3;
        m  = (32'd1 << W) - 1;
        x1 = (fa + fb) & m;
        x2 = (fc - fd) & m;
        x3 = (x1 + x2) & m;
        return (x3 * fd) & ((32'd1 << MULW) - 1);
    endfunction

    // Model: ordered list of in-flight items, each tagged with its depth 1..3 (3 = at output).
    int unsigned q_val[$];
    int          q_pos[$];

    function automatic bit exp_in_ready(input bit ordy);
        int n, lim, np, start;
        n = q_pos.size();
        if (n == 0) return 1'b1;
        if (q_pos[n-1] != 1) return 1'b1;
        start = (q_pos[0] == 3 && ordy) ? 1 : 0;
        lim = 3;
        np  = 1;
        for (int i = start; i < n; i++) begin
            np  = (q_pos[i] + 1 < lim) ? q_pos[i] + 1 : lim;
            lim = np - 1;
        end
        return np > 1;
    endfunction

    bit m_acc;
    int m_lim;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_val.delete();
            q_pos.delete();
        end else if (flush) begin
            q_val.delete();
            q_pos.delete();
        end else begin
            m_acc = in_valid && exp_in_ready(out_ready);
            if (q_pos.size() > 0 && q_pos[0] == 3 && out_ready) begin
                void'(q_val.pop_front());
                void'(q_pos.pop_front());
                emitted++;
            end
            m_lim = 3;
            for (int i = 0; i < q_pos.size(); i++) begin
                q_pos[i] = (q_pos[i] + 1 < m_lim) ? q_pos[i] + 1 : m_lim;
                m_lim    = q_pos[i] - 1;
            end
            if (m_acc) begin
                q_val.push_back(model_f(a, b, c, d));
                q_pos.push_back(1);
            end
        end
    end

    bit ev;
    always @(negedge clk) begin
        if (check_en) begin
            ev = (q_pos.size() > 0) && (q_pos[0] == 3);
            check("out_valid", out_valid, ev);
            check("level", level, q_pos.size());
            check("in_ready", in_ready, exp_in_ready(out_ready));
            if (ev) check("out_f", out_f, q_val[0]);
        end
    end

    // Holds one operand set until accepted; call aligned just after a rising edge.
    task automatic push(input int unsigned ia, ib, ic, id);
        bit f;
        int k;
        in_valid = 1'b1;
        a = W'(ia); b = W'(ib); c = W'(ic); d = W'(id);
        k = 0;
        f = 1'b0;
        while (!f && k < 50) begin
            @(negedge clk);
            f = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        if (!f) check("push_timeout", 0, 1);
    endtask

    task automatic send_one(input int unsigned ia, ib, ic, id, input int unsigned expf, input string nm);
        out_ready = 1'b1;
        push(ia, ib, ic, id);
        check({nm, "_v_edgeN"}, out_valid, 0);
        @(posedge clk); #1;
        check({nm, "_v_edgeN1"}, out_valid, 0);
        @(posedge clk); #1;
        check({nm, "_v_edgeN2"}, out_valid, 1);
        check({nm, "_f"}, out_f, expf);
        @(posedge clk); #1;
        check({nm, "_v_after"}, out_valid, 0);
    endtask

    function automatic int unsigned rnd_op();
        case ($urandom % 4)
            0:       return 0;
            1:       return (32'd1 << W) - 1;
            default: return $urandom % (32'd1 << W);
        endcase
    endfunction

    int          base;
    logic [MULW-1:0] held;

    initial begin
        #1 rst_n = 1'b0;
        #1 check_en = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_f", out_f, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_one(2, 3, 9, 5, 45, "basic45");
        send_one(1023, 1, 0, 1, 1023, "wrap1023");
        send_one(2, 3, 3, 5, 15, "cminusd15");
        send_one(0, 0, 600, 100, 848, "trunc848");

        // Back-to-back burst against a five-cycle stall.
        base = emitted;
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    push(rnd_op(), rnd_op(), rnd_op(), rnd_op());
                    if (k == 2) begin
                        check("stall_level3", level, 3);
                        check("stall_in_ready0", in_ready, 0);
                    end
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                held = out_f;
                check("stall_out_valid", out_valid, 1);
                @(posedge clk); #1;
                check("stall_hold1", out_f, held);
                @(posedge clk); #1;
                check("stall_hold2", out_f, held);
                out_ready = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        check("stall_emitted", emitted - base, 8);
        check("stall_drained", level, 0);

        // Asynchronous reset with two items in flight.
        base = emitted;
        out_ready = 1'b0;
        push(7, 8, 9, 3);
        push(4, 5, 6, 2);
        @(posedge clk); #1;
        check("rmid_pre_valid", out_valid, 1);
        check("rmid_pre_level", level, 2);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_out_valid", out_valid, 0);
        check("rmid_level", level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rmid_not_emitted", emitted - base, 0);

        // Flush overriding a simultaneous accept.
        out_ready = 1'b0;
        push(1, 2, 3, 4);
        push(5, 6, 7, 8);
        flush = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_level", level, 0);
        check("flush_out_valid", out_valid, 0);
        @(posedge clk); #1;
        check("flush_no_accept", level, 0);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 10) < 7;
            out_ready = ($urandom % 10) < 7;
            flush     = ($urandom % 40) == 0;
            a = W'(rnd_op()); b = W'(rnd_op()); c = W'(rnd_op()); d = W'(rnd_op());
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("final_level", level, 0);
        @(negedge clk);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
